// File: rtl/uvma_clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uvma_clk_ctrl_pkg
// Shared types for the uvma_clk_ctrl clock scheduler.
//   cmd_op_t    : command opcodes carried on cmd_op
//   state_t     : scheduler FSM states
//   cmd_illegal : classifies a command as rejected (err) or acceptable
// ---------------------------------------------------------------------------
package uvma_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    START    = 2'd0,
    STOP     = 2'd1,
    SET_HALF = 2'd2,
    RSVD     = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RUN         = 2'd1,
    PEND_STOP   = 2'd2,
    PEND_RELOAD = 2'd3
  } state_t;

  // A zero half-period only matters for the ops that carry one; STOP ignores cmd_half.
  function automatic logic cmd_illegal(input cmd_op_t op, input logic half_zero);
    return (op == RSVD) || (half_zero && ((op == START) || (op == SET_HALF)));
  endfunction

endpackage

// File: rtl/uvma_clk_ctrl_div_cnt.sv
// ---------------------------------------------------------------------------
// uvma_clk_ctrl_div_cnt
// Half-period down counter plus the clk_out toggle register.
//   clk      in   source clock
//   reset    in   asynchronous active-high reset (cnt=0, clk_out=0)
//   en       in   counting enabled (scheduler not idle)
//   load     in   toggle clk_out and reload cnt with load_val
//   load_val in   reload value (half-period in source cycles, >= 1)
//   evt      out  toggle event: en and cnt==1
//   clk_out  out  generated clock
// clk_out only ever changes by inverting: it is low whenever the scheduler
// is idle, so START is a rising toggle and a completed STOP a falling one.
// ---------------------------------------------------------------------------
module uvma_clk_ctrl_div_cnt
  import uvma_clk_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             evt,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;

  assign evt = en && (cnt == CNT_W'(1));

  // The owner always asserts load on evt, so the decrement guard only keeps
  // cnt from ever wrapping below 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      clk_out <= ~clk_out;
    end else if (en && (cnt > CNT_W'(1))) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uvma_clk_ctrl.sv
// ---------------------------------------------------------------------------
// uvma_clk_ctrl
// Clock scheduler: generates, starts, stops and re-times a derived clock.
// Commands arrive over a valid/ready handshake; STOP and SET_HALF take
// effect only on phase boundaries so clk_out never glitches or parks high.
//   clk        in   source clock
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  command accepted when cmd_valid & cmd_ready
//   cmd_op     in   0 START, 1 STOP, 2 SET_HALF, 3 reserved
//   cmd_half   in   half-period for START/SET_HALF (0 rejected)
//   done       out  1-cycle pulse: accepted command took effect
//   err        out  1-cycle pulse: command rejected, no state change
//   clk_out    out  generated clock
//   running    out  high while clk_out toggles (RUN or PEND_*)
//   half_o     out  currently applied half-period
//   cyc_cnt    out  rising edges of clk_out since reset
//                   (only when UVMA_CLK_CTRL_CYC_CNT_EN is defined)
// ---------------------------------------------------------------------------
module uvma_clk_ctrl
  import uvma_clk_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 1
`ifdef UVMA_CLK_CTRL_CYC_CNT_EN
  ,
  parameter int CYC_CNT_W    = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_W-1:0]     cmd_half,
  output logic                 done,
  output logic                 err,
  output logic                 clk_out,
  output logic                 running,
`ifdef UVMA_CLK_CTRL_CYC_CNT_EN
  output logic [CYC_CNT_W-1:0] cyc_cnt,
`endif
  output logic [CNT_W-1:0]     half_o
);

  cmd_op_t          op;
  state_t           state;
  logic [CNT_W-1:0] pend;
  logic             acc;
  logic             bad;
  logic             good;
  logic             start;
  logic             en;
  logic             evt;
  logic             load;
  logic [CNT_W-1:0] load_val;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = ~reset & ((state == IDLE) | (state == RUN));
  assign acc       = cmd_valid & cmd_ready;
  assign bad       = cmd_illegal(op, cmd_half == '0);
  assign good      = acc & ~bad;
  assign start     = good & (state == IDLE) & (op == START);
  assign en        = (state != IDLE);
  assign running   = en;
  assign load      = start | evt;

  // START is the only load while idle; a pending reload takes effect on the
  // first event after it was captured, every other event reuses half_o.
  always_comb begin
    load_val = half_o;
    if (start) begin
      load_val = cmd_half;
    end else if (state == PEND_RELOAD) begin
      load_val = pend;
    end
  end

  uvma_clk_ctrl_div_cnt #(
    .CNT_W (CNT_W)
  ) u_div_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .evt      (evt),
    .clk_out  (clk_out)
  );

  // Pending half-period is plain data: only read in PEND_RELOAD, which is
  // always entered together with a fresh capture.
  always_ff @(posedge clk) begin
    if (good && (state == RUN) && (op == SET_HALF)) begin
      pend <= cmd_half;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      half_o <= CNT_W'(DEFAULT_HALF);
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= acc & bad;
      case (state)
        IDLE: begin
          if (good) begin
            done <= 1'b1;
            if (op != STOP) begin
              half_o <= cmd_half;
            end
            if (op == START) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (good) begin
            case (op)
              START:    done  <= 1'b1;
              SET_HALF: state <= PEND_RELOAD;
              STOP: begin
                // Stop now if clk_out is low and stays low, or if this very
                // cycle is the falling toggle; otherwise wait for the fall.
                if (clk_out == evt) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end else begin
                  state <= PEND_STOP;
                end
              end
              default: ;
            endcase
          end
        end
        PEND_RELOAD: begin
          if (evt) begin
            half_o <= pend;
            state  <= RUN;
            done   <= 1'b1;
          end
        end
        PEND_STOP: begin
          if (evt && clk_out) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UVMA_CLK_CTRL_CYC_CNT_EN
  // Counted on the same edge clk_out rises, so both move together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (load && !clk_out) begin
      cyc_cnt <= cyc_cnt + CYC_CNT_W'(1);
    end
  end
`endif

endmodule
